// File: rtl/button_debounce_pkg.sv
// Shared state encoding for the push-button debouncer.
// Latency: n/a. Backpressure: n/a.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for one asynchronous pin, resetting to a caller-chosen level.
// Latency: 2 clk edges. Backpressure: none.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic rst_val,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw button pin into a clean level, press/release/long strobes and a press count.
// Latency: level and strobes change DEBOUNCE_CYCLES+2 edges after the pin settles. Backpressure: none.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int ACTIVE_LOW        = 1,
    parameter int DEBOUNCE_CYCLES   = 100,
    parameter int LONG_PRESS_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DBC_ONE   = DW'(1);
    localparam logic [DW-1:0] DBC_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic PIN_RELEASED = (ACTIVE_LOW != 0);

    logic          pin_sync;
    logic          s;
    btn_state_t    state, state_n;
    logic [DW-1:0] dbc, dbc_n;
    logic [HW-1:0] hold, hold_n;
    logic          long_done, long_done_n;
    logic          hold_inc;
    logic          level_n, press_n, release_n, long_n;
    logic [7:0]    count_n;

    sync_2ff u_sync (
        .clk     (clk),
        .rst     (rst),
        .d       (btn_in),
        .rst_val (PIN_RELEASED),
        .q       (pin_sync)
    );

    assign s = (ACTIVE_LOW != 0) ? ~pin_sync : pin_sync;

    always_comb begin
        state_n     = state;
        dbc_n       = dbc;
        hold_n      = hold;
        long_done_n = long_done;
        hold_inc    = 1'b0;
        level_n     = btn_level;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        count_n     = press_count;

        case (state)
            IDLE: begin
                if (s) begin
                    state_n = PRESS_WAIT;
                    dbc_n   = DBC_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                    dbc_n   = '0;
                end else if (dbc == DBC_LAST) begin
                    state_n     = PRESSED;
                    dbc_n       = '0;
                    press_n     = 1'b1;
                    level_n     = 1'b1;
                    count_n     = press_count + 8'd1;
                    hold_n      = '0;
                    long_done_n = 1'b0;
                end else begin
                    dbc_n = dbc + 1'b1;
                end
            end
            PRESSED: begin
                if (s) begin
                    hold_inc = 1'b1;
                end else begin
                    state_n = RELEASE_WAIT;
                    dbc_n   = DBC_ONE;
                end
            end
            RELEASE_WAIT: begin
                // Returning to held counts as a held cycle so a glitch costs only its own length.
                if (s) begin
                    state_n  = PRESSED;
                    hold_inc = 1'b1;
                end else if (dbc == DBC_LAST) begin
                    state_n   = IDLE;
                    dbc_n     = '0;
                    release_n = 1'b1;
                    level_n   = 1'b0;
                end else begin
                    dbc_n = dbc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (hold_inc) begin
            if (hold != HOLD_MAX) begin
                hold_n = hold + 1'b1;
            end
            if (hold_n == HOLD_LONG && !long_done) begin
                long_n      = 1'b1;
                long_done_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dbc           <= '0;
            hold          <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_n;
            dbc           <= dbc_n;
            hold          <= hold_n;
            long_done     <= long_done_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
            press_count   <= count_n;
        end
    end

endmodule
